// File: rtl/dino_game_engine.sv
// Frame-rate game-state engine for the dino runner: jump physics, cactus scroll,
// collision and IDLE/RUN/OVER control. Define DINO_SPEEDUP_EN to enable scroll speed-up.
module dino_game_engine #(
    parameter int GROUND_Y   = 400,
    parameter int DINO_X     = 64,
    parameter int DINO_W     = 40,
    parameter int DINO_H     = 43,
    parameter int OBS_W      = 25,
    parameter int OBS_H      = 50,
    parameter int SCREEN_W   = 640,
    parameter int JUMP_V     = 20,
    parameter int GRAVITY    = 1,
    parameter int SPEED_INIT = 4,
    parameter int SPEED_MAX  = 12
) (
    input  logic        pixel_clk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic        jump,
    input  logic        restart,
    output logic [11:0] dino_y,
    output logic [11:0] obstacle_x,
    output logic        game_over,
    output logic [15:0] score
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_OVER = 2'd2;

    localparam logic [11:0]        C_Y0       = 12'(GROUND_Y - DINO_H);
    localparam logic [11:0]        C_X0       = 12'(SCREEN_W);
    localparam logic [3:0]         C_SPEED0   = 4'(SPEED_INIT);
    localparam logic [11:0]        C_JUMP_H   = 12'(JUMP_V);
    localparam logic signed [7:0]  C_JUMP_VEL = 8'(JUMP_V - GRAVITY);
    localparam logic signed [7:0]  C_GRAV     = 8'(GRAVITY);
    localparam logic signed [12:0] C_HIT_L    = 13'(DINO_X + DINO_W);
    localparam logic signed [12:0] C_HIT_R    = 13'(DINO_X);
    localparam logic signed [12:0] C_OBS_W    = 13'(OBS_W);
    localparam logic signed [12:0] C_OBS_H    = 13'(OBS_H);

    logic [1:0]         r_state;
    logic [11:0]        r_h;
    logic signed [7:0]  r_vel;
    logic               r_jump_req;
    logic               r_jump_d;
    logic               r_restart_d;
    logic [11:0]        r_dino_y;
    logic [11:0]        r_obs_x;
    logic               r_game_over;
    logic [15:0]        r_score;

    logic               w_jump_rise;
    logic               w_restart_rise;
    logic               w_run_tick;
    logic               w_grounded;
    logic signed [12:0] w_h_sum;
    logic [11:0]        w_h_nxt;
    logic signed [7:0]  w_vel_nxt;
    logic               w_obs_wrap;
    logic [11:0]        w_obs_nxt;
    logic [15:0]        w_score_nxt;
    logic               w_score_inc;
    logic signed [12:0] w_obs_s;
    logic               w_hit;
    logic [3:0]         w_speed;

    assign w_jump_rise    = jump & ~r_jump_d;
    assign w_restart_rise = restart & ~r_restart_d;
    assign w_run_tick     = frame_tick &
                            ((r_state == S_RUN) || ((r_state == S_IDLE) && r_jump_req));

    // Signed 13-bit sum so a descending dino can be seen reaching or passing the ground.
    assign w_grounded = (r_h == 12'd0) && (r_vel == 8'sd0);
    assign w_h_sum    = $signed({1'b0, r_h}) + 13'(r_vel);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_h_nxt   = r_h;
        w_vel_nxt = r_vel;
        if (w_grounded) begin
            if (r_jump_req) begin
                w_h_nxt   = C_JUMP_H;
                w_vel_nxt = C_JUMP_VEL;
            end
        end else if (w_h_sum <= 13'sd0) begin
            w_h_nxt   = 12'd0;
            w_vel_nxt = 8'sd0;
        end else begin
            w_h_nxt   = w_h_sum[11:0];
            w_vel_nxt = r_vel - C_GRAV;
        end
    end

    always_comb begin
        w_obs_wrap  = (r_obs_x <= {8'd0, w_speed});
        w_obs_nxt   = w_obs_wrap ? C_X0 : (r_obs_x - {8'd0, w_speed});
        w_score_inc = w_obs_wrap && (r_score != 16'hFFFF);
        w_score_nxt = w_score_inc ? (r_score + 16'd1) : r_score;
    end

    // Collision uses the post-update obstacle and height, so a wrap never collides.
    assign w_obs_s = $signed({1'b0, w_obs_nxt});
    assign w_hit   = (w_obs_s < C_HIT_L) &&
                     ((w_obs_s + C_OBS_W) > C_HIT_R) &&
                     ($signed({1'b0, w_h_nxt}) < C_OBS_H);

`ifdef DINO_SPEEDUP_EN
    logic [3:0] r_speed;

    assign w_speed = r_speed;

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_speed <= C_SPEED0;
        end else if ((r_state == S_OVER) && w_restart_rise) begin
            r_speed <= C_SPEED0;
        end else if (w_run_tick && w_score_inc && (w_score_nxt[2:0] == 3'd0) &&
                     (32'(r_speed) < SPEED_MAX)) begin
            r_speed <= r_speed + 4'd1;
        end
    end
`else
    assign w_speed = C_SPEED0;
`endif

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_h         <= 12'd0;
            r_vel       <= 8'sd0;
            r_jump_req  <= 1'b0;
            r_jump_d    <= 1'b0;
            r_restart_d <= 1'b0;
            r_dino_y    <= C_Y0;
            r_obs_x     <= C_X0;
            r_game_over <= 1'b0;
            r_score     <= 16'd0;
        end else begin
            r_jump_d    <= jump;
            r_restart_d <= restart;

            // A new edge outranks the tick clear, so it carries over to the next tick.
            if (r_state == S_OVER) begin
                r_jump_req <= 1'b0;
            end else if (w_jump_rise) begin
                r_jump_req <= 1'b1;
            end else if (frame_tick) begin
                r_jump_req <= 1'b0;
            end

            if (w_run_tick) begin
                r_h         <= w_h_nxt;
                r_vel       <= w_vel_nxt;
                r_dino_y    <= C_Y0 - w_h_nxt;
                r_obs_x     <= w_obs_nxt;
                r_score     <= w_score_nxt;
                r_game_over <= w_hit;
                r_state     <= w_hit ? S_OVER : S_RUN;
            end else if ((r_state == S_OVER) && w_restart_rise) begin
                r_h         <= 12'd0;
                r_vel       <= 8'sd0;
                r_dino_y    <= C_Y0;
                r_obs_x     <= C_X0;
                r_score     <= 16'd0;
                r_game_over <= 1'b0;
                r_state     <= S_IDLE;
            end
        end
    end

    assign dino_y     = r_dino_y;
    assign obstacle_x = r_obs_x;
    assign game_over  = r_game_over;
    assign score      = r_score;

endmodule

// File: tb/tb_dino_game_engine.sv
// Directed bench for dino_game_engine: a default instance plus one with OBS_H=0
// that can never collide, both driven by the same buttons and frame ticks.
module tb_dino_game_engine;

    logic        pixel_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_tick = 1'b0;
    logic        jump = 1'b0;
    logic        restart = 1'b0;

    logic [11:0] dino_y, obstacle_x;
    logic        game_over;
    logic [15:0] score;
    logic [11:0] nc_dino_y, nc_obstacle_x;
    logic        nc_game_over;
    logic [15:0] nc_score;

    int n_pass = 0;
    int n_total = 0;

    always #5 pixel_clk = ~pixel_clk;

    dino_game_engine u_dut (
        .pixel_clk  (pixel_clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .jump       (jump),
        .restart    (restart),
        .dino_y     (dino_y),
        .obstacle_x (obstacle_x),
        .game_over  (game_over),
        .score      (score)
    );

    dino_game_engine #(.OBS_H(0)) u_dut_nc (
        .pixel_clk  (pixel_clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .jump       (jump),
        .restart    (restart),
        .dino_y     (nc_dino_y),
        .obstacle_x (nc_obstacle_x),
        .game_over  (nc_game_over),
        .score      (nc_score)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_total++;
        assert (observed === expected) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    endtask

    task automatic tick();
        @(negedge pixel_clk) frame_tick = 1'b1;
        @(negedge pixel_clk) frame_tick = 1'b0;
        @(negedge pixel_clk);
    endtask

    task automatic press_jump();
        @(negedge pixel_clk) jump = 1'b1;
        @(negedge pixel_clk) jump = 1'b0;
    endtask

`ifdef DINO_SPEEDUP_EN
    localparam int SPD_AFTER8 = 5;
`else
    localparam int SPD_AFTER8 = 4;
`endif

    initial begin
        int budget;

        repeat (3) @(negedge pixel_clk);
        check("rst_dino_y", 32'(dino_y), 357);
        check("rst_obs_x", 32'(obstacle_x), 640);
        check("rst_game_over", 32'(game_over), 0);
        check("rst_score", 32'(score), 0);
        @(negedge pixel_clk) rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_dino_y", 32'(dino_y), 357);
            check("idle_obs_x", 32'(obstacle_x), 640);
            check("idle_state", {game_over, score}, 0);
        end

        press_jump();
        for (int i = 1; i <= 160; i++) begin
            tick();
            if (i == 1) check("jump_t1_dino_y", 32'(nc_dino_y), 337);
            if (i == 20) begin
                check("apex_dino_y", 32'(nc_dino_y), 147);
                check("apex_dino_y_def", 32'(dino_y), 147);
            end
            if (i == 40) check("pre_land_dino_y", 32'(nc_dino_y), 337);
            if (i == 41) check("land_dino_y", 32'(nc_dino_y), 357);
            if (i == 42) check("grounded_dino_y", 32'(nc_dino_y), 357);
            if (i == 134) begin
                check("pre_hit_obs_x", 32'(obstacle_x), 104);
                check("pre_hit_game_over", 32'(game_over), 0);
            end
            if (i == 135) begin
                check("hit_obs_x", 32'(obstacle_x), 100);
                check("hit_game_over", 32'(game_over), 1);
                check("nc_no_hit", 32'(nc_game_over), 0);
            end
            if (i > 135 && i <= 155) check("over_frozen_obs_x", 32'(obstacle_x), 100);
            if (i == 155) begin
                check("over_frozen_dino_y", 32'(dino_y), 357);
                check("over_frozen_go", 32'(game_over), 1);
                check("over_frozen_score", 32'(score), 0);
            end
            if (i == 159) check("wrap_pre_obs_x", 32'(nc_obstacle_x), 4);
            if (i == 160) begin
                check("wrap_obs_x", 32'(nc_obstacle_x), 640);
                check("wrap_score", 32'(nc_score), 1);
            end
        end

        for (int i = 0; i < 3; i++) begin
            press_jump();
            tick();
        end
        check("over_jump_dino_y", 32'(dino_y), 357);
        check("over_jump_obs_x", 32'(obstacle_x), 100);
        check("over_jump_go", 32'(game_over), 1);

        @(negedge pixel_clk) restart = 1'b1;
        repeat (3) @(negedge pixel_clk);
        restart = 1'b0;
        tick();
        check("restart_dino_y", 32'(dino_y), 357);
        check("restart_obs_x", 32'(obstacle_x), 640);
        check("restart_go", 32'(game_over), 0);
        check("restart_score", 32'(score), 0);
        check("nc_restart_ignored", {15'd0, nc_game_over, nc_score}, 1);

        budget = 1500;
        while (nc_score < 16'd8 && budget > 0) begin
            tick();
            budget--;
        end
        check("score8_reached", 32'(nc_score), 8);
        check("score8_obs_x", 32'(nc_obstacle_x), 640);
        tick();
        check("speed_after8", 32'(nc_obstacle_x), 640 - SPD_AFTER8);
        check("idle_kept", 32'(obstacle_x), 640);

        press_jump();
        tick();
        tick();
        tick();
        check("midjump_dino_y", 32'(dino_y), 300);
        check("midjump_obs_x", 32'(obstacle_x), 628);
        @(negedge pixel_clk) rst_n = 1'b0;
        #1;
        check("async_rst_dino_y", 32'(dino_y), 357);
        check("async_rst_obs_x", 32'(obstacle_x), 640);
        check("async_rst_go", 32'(game_over), 0);
        check("async_rst_nc_score", 32'(nc_score), 0);
        check("async_rst_nc_obs_x", 32'(nc_obstacle_x), 640);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
